sobel_window: RTL and testbench
===============================

SOBEL_WINDOW -- requirements
Module: sobel_window

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, pixels per line (at least 3).
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, lines per frame (at least 3).
REQ-003 SHALL have parameter EDGE_THRESH, default 128, edge decision threshold on magnitude (0..255).
REQ-004 sys_clk_i  input  1  single clock; all logic on rising edge.
REQ-005 sys_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 grey_dt_i  input  8  greyscale pixel, unsigned, raster order.
REQ-007 done_i  input  1  pixel valid qualifier; grey_dt_i is accepted on any rising edge where done_i=1.
REQ-008 sof_i  input  1  start-of-frame; synchronous resync of position counters.
REQ-009 mag_dt_o  output  8  saturated Sobel gradient magnitude.
REQ-010 edge_o  output  1  1 when mag_dt_o >= EDGE_THRESH, qualified by done_o.
REQ-011 done_o  output  1  output valid; one-cycle pulse per result.
REQ-012 frame_done_o  output  1  one-cycle pulse coincident with the last result of a frame.

Function
REQ-013 SHALL hold a column counter (0..IMG_WIDTH-1) and a row counter (0..IMG_HEIGHT-1); both advance only on accepted pixels; column wraps to 0 and increments row; row wraps to 0 after (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-014 SHALL store the two most recent complete lines in two IMG_WIDTH x 8 line buffers, indexed by column, and write each accepted pixel into the rotation at its column.
REQ-015 SHALL keep a 3x3 window p[r][c] (r=0 oldest line, c=2 newest column), shifted one column per accepted pixel; no shift when done_i=0.
REQ-016 Gx SHALL = (p02+2p12+p22)-(p00+2p10+p20); Gy SHALL = (p20+2p21+p22)-(p00+2p01+p02); both 11-bit signed, no overflow.
REQ-017 Magnitude SHALL = |Gx|+|Gy| (12-bit unsigned), saturated to 255 on mag_dt_o.
REQ-018 A result SHALL be produced only for accepted pixels with row>=2 and col>=2; it represents center pixel (row-1, col-1); border pixels produce no result; (IMG_WIDTH-2)*(IMG_HEIGHT-2) results per frame.
REQ-019 Latency SHALL be exactly 2 clocks: pixel accepted at edge k gives done_o=1 after edge k+2, for one cycle.
REQ-020 Operating states SHALL be FILL (row<2, no results) and STREAM (row>=2); the FILL-to-STREAM transition happens when row advances to 2; STREAM returns to FILL on row wrap or sof_i.
REQ-021 Pipeline SHALL stay correct with arbitrary done_i gaps; back-to-back done_i gives one result per clock.
REQ-022 When done_o=0, mag_dt_o and edge_o SHALL be 0.
REQ-023 frame_done_o SHALL pulse with the done_o of the result from input pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-024 sof_i=1 SHALL clear both counters before the same-edge pixel is accepted, so a coincident done_i pixel is (0,0); results already in the pipeline SHALL still emit.
REQ-025 Line buffer contents SHALL NOT need reset; FILL guarantees no stale data reaches a result.

Reset
REQ-026 While sys_rst_i=1, independent of the clock: counters=0, state=FILL, pipeline valids=0, mag_dt_o=0, edge_o=0, done_o=0, frame_done_o=0.
REQ-027 After sys_rst_i deasserts, the first accepted pixel SHALL be (0,0); reset mid-frame discards in-flight results with no done_o.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, EDGE_THRESH=128)
REQ-028 Constant 100 frame, continuous done_i -> 24 done_o pulses, all mag_dt_o=0, edge_o=0, one frame_done_o on the 24th.
REQ-029 Vertical step, cols 0-3 = 0 and cols 4-7 = 200 -> centers col 3 and col 4 give mag_dt_o=255, edge_o=1; all others give 0.
REQ-030 Horizontal ramp, pixel=col*10 -> every result mag_dt_o=80, edge_o=0.
REQ-031 Run the REQ-029 frame with random done_i gaps (0-3 idle cycles) -> identical result sequence; each result 2 clocks after its completing pixel.
REQ-032 Assert sys_rst_i asynchronously mid-row 3 -> outputs 0 immediately; a fresh frame then gives exactly 24 results.
REQ-033 Assert sof_i with done_i at pixel (4,2) -> that pixel is treated as (0,0); no results until row 2 col 2 of the new frame.

Source files
------------

// File: rtl/sobel_window_if.sv
// Pixel stream bundle for the Sobel window: greyscale pixels in, gradient
// magnitude and edge flags out.
interface sobel_window_if;
  logic [7:0] grey_dt_i;
  logic       done_i;
  logic       sof_i;
  logic [7:0] mag_dt_o;
  logic       edge_o;
  logic       done_o;
  logic       frame_done_o;

  modport slave (
    input  grey_dt_i, done_i, sof_i,
    output mag_dt_o, edge_o, done_o, frame_done_o
  );

  modport master (
    output grey_dt_i, done_i, sof_i,
    input  mag_dt_o, edge_o, done_o, frame_done_o
  );
endinterface

// File: rtl/sobel_window.sv
// 3x3 Sobel edge detector over a raster pixel stream, using two line buffers
// and a three-stage pipeline (window / gradient / saturate+threshold).
module sobel_window #(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int EDGE_THRESH = 128
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  sobel_window_if.slave pix_if
);
  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [7:0]       THRESH   = 8'(EDGE_THRESH);

  typedef enum logic {FILL, STREAM} state_t;

  function automatic logic signed [10:0] ext11(input logic [7:0] v);
    return $signed({3'b000, v});
  endfunction

  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    logic [10:0] u;
    u = v[10] ? 11'(-v) : 11'(v);
    return u;
  endfunction

  function automatic logic [7:0] sat8(input logic [11:0] v);
    return (v > 12'd255) ? 8'hFF : v[7:0];
  endfunction

  state_t           state_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_eff;
  logic [ROW_W-1:0] row_eff;
  logic             stream_eff, col_last, row_last, accept;

  logic [7:0] lb0_q [IMG_WIDTH];
  logic [7:0] lb1_q [IMG_WIDTH];
  logic [7:0] win_q [3][3];

  logic              vld_p0_q, frm_p0_q;
  logic              vld_p1_q, frm_p1_q;
  logic [11:0]       mag_p1_q;
  logic signed [10:0] gx_p0, gy_p0;
  logic [7:0]        mag_sat_p1;

  logic [7:0] mag_q;
  logic       edge_q, done_q, frame_done_q;

  // sof_i resynchronises the position before the coincident pixel is placed
  assign accept     = pix_if.done_i;
  assign col_eff    = pix_if.sof_i ? '0 : col_q;
  assign row_eff    = pix_if.sof_i ? '0 : row_q;
  assign stream_eff = !pix_if.sof_i && (state_q == STREAM);
  assign col_last   = (col_eff == COL_LAST);
  assign row_last   = (row_eff == ROW_LAST);

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= FILL;
    end else if (accept) begin
      if (col_last) begin
        col_q <= '0;
        if (row_last) begin
          row_q   <= '0;
          state_q <= FILL;
        end else begin
          row_q <= row_eff + ROW_W'(1);
          case (state_q)
            FILL:    state_q <= (row_eff == ROW_W'(1)) ? STREAM : FILL;
            STREAM:  state_q <= (stream_eff || row_eff == ROW_W'(1)) ? STREAM : FILL;
            default: state_q <= FILL;
          endcase
        end
      end else begin
        col_q   <= col_eff + COL_W'(1);
        row_q   <= row_eff;
        state_q <= stream_eff ? STREAM : FILL;
      end
    end else if (pix_if.sof_i) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= FILL;
    end
  end

  // ---- stage p0: line buffer rotation and window shift ----
  always_ff @(posedge sys_clk_i) begin
    if (accept) begin
      lb0_q[col_eff] <= lb1_q[col_eff];
      lb1_q[col_eff] <= pix_if.grey_dt_i;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb0_q[col_eff];
      win_q[1][2] <= lb1_q[col_eff];
      win_q[2][2] <= pix_if.grey_dt_i;
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      vld_p0_q <= 1'b0;
      frm_p0_q <= 1'b0;
    end else begin
      vld_p0_q <= accept && stream_eff && (col_eff >= COL_W'(2));
      frm_p0_q <= accept && stream_eff && row_last && col_last;
    end
  end

  // ---- stage p1: gradients and magnitude ----
  always_comb begin
    gx_p0 = (ext11(win_q[0][2]) + (ext11(win_q[1][2]) <<< 1) + ext11(win_q[2][2]))
          - (ext11(win_q[0][0]) + (ext11(win_q[1][0]) <<< 1) + ext11(win_q[2][0]));
    gy_p0 = (ext11(win_q[2][0]) + (ext11(win_q[2][1]) <<< 1) + ext11(win_q[2][2]))
          - (ext11(win_q[0][0]) + (ext11(win_q[0][1]) <<< 1) + ext11(win_q[0][2]));
  end

  always_ff @(posedge sys_clk_i) begin
    mag_p1_q <= {1'b0, abs11(gx_p0)} + {1'b0, abs11(gy_p0)};
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      vld_p1_q <= 1'b0;
      frm_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p0_q;
      frm_p1_q <= frm_p0_q;
    end
  end

  // ---- stage p2: saturation, threshold, gated outputs ----
  assign mag_sat_p1 = sat8(mag_p1_q);

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      mag_q        <= '0;
      edge_q       <= 1'b0;
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      mag_q        <= vld_p1_q ? mag_sat_p1 : 8'd0;
      edge_q       <= vld_p1_q && (mag_sat_p1 >= THRESH);
      done_q       <= vld_p1_q;
      frame_done_q <= vld_p1_q && frm_p1_q;
    end
  end

  assign pix_if.mag_dt_o     = mag_q;
  assign pix_if.edge_o       = edge_q;
  assign pix_if.done_o       = done_q;
  assign pix_if.frame_done_o = frame_done_q;
endmodule

// File: tb/tb_sobel_window.sv
// Directed bench for sobel_window: a reference Sobel model fills a scoreboard
// as pixels are driven; a negedge monitor pops and compares each result.
module tb_sobel_window;
  localparam int W = 8;
  localparam int H = 6;
  localparam int T = 128;

  logic clk = 1'b0;
  logic rst;
  sobel_window_if bus ();

  sobel_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .EDGE_THRESH(T)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .pix_if    (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int mag; int edg; int frm; int due;} exp_t;
  exp_t sbq[$];

  int n_chk = 0;
  int n_err = 0;
  int n_res = 0;
  int img [H][W];
  int r_m = 0;
  int c_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_expect(input int r, input int c, input int k);
    int p [3][3];
    int gx, gy, m;
    exp_t e;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = img[r-2+i][c-2+j];
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    e.mag = (m > 255) ? 255 : m;
    e.edg = (e.mag >= T) ? 1 : 0;
    e.frm = (r == H-1 && c == W-1) ? 1 : 0;
    e.due = k + 2;
    sbq.push_back(e);
  endtask

  task automatic send_px(input bit sof);
    int k;
    if (sof) begin
      r_m = 0;
      c_m = 0;
    end
    bus.grey_dt_i = 8'(img[r_m][c_m]);
    bus.done_i    = 1'b1;
    bus.sof_i     = sof;
    @(posedge clk);
    #1;
    k = cyc;
    if (r_m >= 2 && c_m >= 2) push_expect(r_m, c_m, k);
    if (c_m == W-1) begin
      c_m = 0;
      r_m = (r_m == H-1) ? 0 : r_m + 1;
    end else begin
      c_m = c_m + 1;
    end
    bus.done_i = 1'b0;
    bus.sof_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.done_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int gapmax);
    for (int i = 0; i < W*H; i++) begin
      send_px(1'b0);
      if (gapmax > 0) idle($urandom_range(gapmax, 0));
    end
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sbq.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    chk({tag, "_drained"}, sbq.size(), 0);
  endtask

  task automatic set_step();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (c < 4) ? 0 : 200;
  endtask

  // Result monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done_o === 1'b1) begin
        n_res++;
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("mag", bus.mag_dt_o, e.mag);
          chk("edge", bus.edge_o, e.edg);
          chk("frame_done", bus.frame_done_o, e.frm);
          chk("latency", cyc, e.due);
        end
      end else begin
        chk("idle_zero", {bus.done_o, bus.mag_dt_o, bus.edge_o, bus.frame_done_o}, 0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish (observed hang, expected completion)");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.grey_dt_i = 8'd0;
    bus.done_i    = 1'b0;
    bus.sof_i     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", bus.done_o, 0);
    chk("rst_mag", bus.mag_dt_o, 0);
    chk("rst_edge", bus.edge_o, 0);
    chk("rst_frame_done", bus.frame_done_o, 0);
    rst = 1'b0;
    idle(2);

    // Constant frame
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 100;
    n_res = 0;
    run_frame(0);
    drain("const");
    chk("const_count", n_res, 24);

    // Vertical step
    set_step();
    n_res = 0;
    run_frame(0);
    drain("step");
    chk("step_count", n_res, 24);

    // Horizontal ramp
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = c * 10;
    n_res = 0;
    run_frame(0);
    drain("ramp");
    chk("ramp_count", n_res, 24);

    // Vertical step with random idle gaps
    set_step();
    n_res = 0;
    run_frame(3);
    drain("gaps");
    chk("gaps_count", n_res, 24);

    // Asynchronous reset in row 3
    for (int i = 0; i < 3*W + 4; i++) send_px(1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_done", bus.done_o, 0);
    chk("arst_mag", bus.mag_dt_o, 0);
    chk("arst_edge", bus.edge_o, 0);
    chk("arst_frame_done", bus.frame_done_o, 0);
    sbq.delete();
    r_m = 0;
    c_m = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    n_res = 0;
    run_frame(0);
    drain("post_rst");
    chk("post_rst_count", n_res, 24);

    // sof at pixel (4,2): 12 results from the aborted frame, then a full frame
    n_res = 0;
    for (int i = 0; i < 4*W + 2; i++) send_px(1'b0);
    send_px(1'b1);
    for (int i = 1; i < W*H; i++) send_px(1'b0);
    drain("sof");
    chk("sof_count", n_res, 36);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
